// File: rtl/bcd_digit_sequencer_pkg.sv
// Shared types and constants for the BCD digit sequencer and its add-3 nibble cell.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bcd_digit_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    typedef logic [3:0] bcd_nibble_t;

    // Non-decimal digit code; the downstream 7-segment decoder shows nothing for it.
    localparam bcd_nibble_t BLANK_CODE  = 4'hF;
    // Double-dabble correction threshold: a nibble at or above this gets +3 before the shift.
    localparam bcd_nibble_t ADD3_THRESH = 4'd5;

    // Constant helper for the elaboration-time range check (10^n).
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_sequencer_add3_nibble.sv
// One double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
// Latency: purely combinational.
// Backpressure: none.
module bcd_add3_nibble
    import bcd_digit_sequencer_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    // Pre-shift correction so that the following left shift carries into the next decade.
    always_comb begin
        nib_out = nib_in;
        if (nib_in >= ADD3_THRESH) begin
            nib_out = nib_in + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Latches a binary value, converts it to BCD by shift-add-3, then emits one digit per cycle (MSD first).
// Latency: start accepted at edge k -> digits in cycles k+WIDTH+1 .. k+WIDTH+NUM_DIGITS, done one cycle later.
// Backpressure: none; start is only honoured in IDLE, and starts while busy are dropped, not queued.
// Build option: define LEAD_ZERO_BLANK_EN to emit leading zero digits (except the last) as the blank code.
module bcd_digit_sequencer
    import bcd_digit_sequencer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_val,
    output logic                  busy,
    output logic [3:0]            addr,
    output logic                  act_D,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  done
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]      MSD_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_LSD   = NUM_DIGITS'(1);

    // The digit count must cover the largest input, otherwise the BCD register would overflow.
    if (pow10(NUM_DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_range_fail
        $fatal(1, "bcd_digit_sequencer: NUM_DIGITS too small for WIDTH");
    end

    seq_state_t       state;
    logic [WIDTH-1:0] bin_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [CNT_W-1:0] iter_cnt;
    logic [IDX_W-1:0] dig_idx;

    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_shift;
    logic             unused_bcd_msb;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3_nibble u_add3 (
            .nib_in  (bcd_reg[4*g +: 4]),
            .nib_out (bcd_adj[4*g +: 4])
        );
    end

    // One double-dabble step: corrected BCD shifted left, taking in the binary MSB.
    assign bcd_shift      = {bcd_adj[BCD_W-2:0], bin_reg[WIDTH-1]};
    // The range check guarantees the shifted-out BCD bit is always zero.
    assign unused_bcd_msb = bcd_adj[BCD_W-1];

    // Code presented for digit idx of a finished BCD value, with optional leading-zero blanking.
    function automatic logic [3:0] digit_code(input logic [BCD_W-1:0] bcd,
                                              input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        nib = bcd[4*idx +: 4];
`ifdef LEAD_ZERO_BLANK_EN
        // Blank only when this digit and every more significant one are zero; never the last digit.
        if ((idx != '0) && ((bcd >> (4*idx)) == '0)) begin
            nib = BLANK_CODE;
        end
`endif
        return nib;
    endfunction

    // Sequencer FSM: registered outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            iter_cnt  <= '0;
            dig_idx   <= '0;
            busy      <= 1'b0;
            addr      <= BLANK_CODE;
            act_D     <= 1'b0;
            digit_sel <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_reg  <= bin_val;
                        bcd_reg  <= '0;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end

                CONVERT: begin
                    bin_reg  <= bin_reg << 1;
                    bcd_reg  <= bcd_shift;
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_ITER) begin
                        // Most significant digit goes out straight from the final step's result.
                        dig_idx   <= MSD_IDX;
                        act_D     <= 1'b1;
                        addr      <= digit_code(bcd_shift, MSD_IDX);
                        digit_sel <= SEL_LSD << MSD_IDX;
                        state     <= EMIT;
                    end
                end

                EMIT: begin
                    if (dig_idx == '0) begin
                        act_D     <= 1'b0;
                        addr      <= BLANK_CODE;
                        digit_sel <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        dig_idx   <= dig_idx - 1'b1;
                        addr      <= digit_code(bcd_reg, dig_idx - 1'b1);
                        digit_sel <= digit_sel >> 1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Directed bench for bcd_digit_sequencer with hand-computed digit vectors.
// Latency: expects digits in cycles 9..11 after the start edge, done at 12, idle at 13.
// Backpressure: exercises ignored starts, mid-run reset and continuously held start.
module tb_bcd_digit_sequencer;

`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] bin_val;
    logic       busy;
    logic [3:0] addr;
    logic       act_D;
    logic [2:0] digit_sel;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    bcd_digit_sequencer #(.WIDTH(8), .NUM_DIGITS(3)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .bin_val   (bin_val),
        .busy      (busy),
        .addr      (addr),
        .act_D     (act_D),
        .digit_sel (digit_sel),
        .done      (done)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'hF);
        check({tag, "_act"},  32'(act_D), 32'd0);
        check({tag, "_sel"},  32'(digit_sel), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Runs one conversion and checks every cycle 1..13 after the start edge.
    // pulse_at: cycle at which a second start (value 99) is pulsed; 0 = none.
    // reset_at: cycle after whose checks resetn is dropped; 0 = none.
    // hold: keep start high throughout.
    task automatic run(input string tag, input logic [7:0] val,
                       input logic [3:0] e2, input logic [3:0] e1, input logic [3:0] e0,
                       input int pulse_at, input int reset_at, input bit hold);
        int act_cnt;
        int done_cnt;
        logic [3:0] exp_addr;
        logic [2:0] exp_sel;
        act_cnt  = 0;
        done_cnt = 0;
        start    = 1'b1;
        bin_val  = val;
        tick();
        for (int n = 1; n <= 13; n++) begin
            if (n > 1) begin
                tick();
            end
            if (!hold && n != pulse_at + 1) begin
                start = 1'b0;
            end
            case (n)
                9:       begin exp_addr = e2;   exp_sel = 3'b100; end
                10:      begin exp_addr = e1;   exp_sel = 3'b010; end
                11:      begin exp_addr = e0;   exp_sel = 3'b001; end
                default: begin exp_addr = 4'hF; exp_sel = 3'b000; end
            endcase
            check($sformatf("%s_c%0d_busy", tag, n), 32'(busy), 32'(n <= 12));
            check($sformatf("%s_c%0d_act", tag, n), 32'(act_D), 32'(n >= 9 && n <= 11));
            check($sformatf("%s_c%0d_addr", tag, n), 32'(addr), 32'(exp_addr));
            check($sformatf("%s_c%0d_sel", tag, n), 32'(digit_sel), 32'(exp_sel));
            check($sformatf("%s_c%0d_done", tag, n), 32'(done), 32'(n == 12));
            if (act_D) act_cnt++;
            if (done)  done_cnt++;
            if (n == pulse_at) begin
                start   = 1'b1;
                bin_val = 8'd99;
            end
            if (n == reset_at) begin
                resetn = 1'b0;
                tick();
                check_reset_vals({tag, "_rst"});
                resetn = 1'b1;
                start  = 1'b0;
                for (int q = 0; q < 15; q++) begin
                    tick();
                    check($sformatf("%s_post_rst%0d_act", tag, q), 32'(act_D), 32'd0);
                    check($sformatf("%s_post_rst%0d_done", tag, q), 32'(done), 32'd0);
                end
                return;
            end
        end
        check({tag, "_act_count"}, 32'(act_cnt), 32'd3);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        resetn  = 1'b0;
        start   = 1'b0;
        bin_val = 8'd0;
        tick();
        tick();
        check_reset_vals("reset");
        resetn = 1'b1;
        tick();
        check_reset_vals("idle");

        run("v173", 8'd173, 4'd1, 4'd7, 4'd3, 0, 0, 1'b0);
        run("v255", 8'd255, 4'd2, 4'd5, 4'd5, 0, 0, 1'b0);
        run("v9",   8'd9,   LZB ? 4'hF : 4'd0, LZB ? 4'hF : 4'd0, 4'd9, 0, 0, 1'b0);
        run("v0",   8'd0,   LZB ? 4'hF : 4'd0, LZB ? 4'hF : 4'd0, 4'd0, 0, 0, 1'b0);
        run("v100", 8'd100, 4'd1, 4'd0, 4'd0, 0, 0, 1'b0);

        // Second start at cycle 4 with a different value must be ignored.
        run("ign",  8'd42,  LZB ? 4'hF : 4'd0, 4'd4, 4'd2, 4, 0, 1'b0);
        for (int q = 0; q < 5; q++) begin
            tick();
            check($sformatf("ign_after%0d_done", q), 32'(done), 32'd0);
            check($sformatf("ign_after%0d_busy", q), 32'(busy), 32'd0);
        end

        // Reset during the second emitted digit aborts the run.
        run("abort", 8'd173, 4'd1, 4'd7, 4'd3, 0, 10, 1'b0);
        run("v7",    8'd7,   LZB ? 4'hF : 4'd0, LZB ? 4'hF : 4'd0, 4'd7, 0, 0, 1'b0);

        // Start held high: back-to-back runs every 13 cycles.
        run("hold0", 8'd1, LZB ? 4'hF : 4'd0, LZB ? 4'hF : 4'd0, 4'd1, 0, 0, 1'b1);
        run("hold1", 8'd1, LZB ? 4'hF : 4'd0, LZB ? 4'hF : 4'd0, 4'd1, 0, 0, 1'b1);
        run("hold2", 8'd1, LZB ? 4'hF : 4'd0, LZB ? 4'hF : 4'd0, 4'd1, 0, 0, 1'b1);
        start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_digit_sequencer.md
Name: bcd_digit_sequencer

Overview:
Upstream feeder for the 7-segment display generator. It latches a binary count (e.g. train step or electrode index), converts it to BCD with a sequential shift-add-3 (double-dabble) engine, then presents digits one per cycle. Each digit goes out on a 4-bit digit code with a one-cycle activation strobe and a one-hot digit select, so one display decoder can drive a multi-digit display.

Parameters:
WIDTH, 8, bit width of the binary input value.
NUM_DIGITS, 3, number of BCD digits produced. Elaboration-time check: 10^NUM_DIGITS > 2^WIDTH - 1, else fatal error.

Ports:
clock  input  1  system clock; all logic on rising edge.
resetn  input  1  synchronous active-low reset.
start  input  1  request conversion of bin_val; sampled only in IDLE.
bin_val  input  WIDTH  binary value to convert; latched on accepted start.
busy  output  1  high in CONVERT, EMIT and DONE.
addr  output  4  current BCD digit code for the display decoder.
act_D  output  1  one-cycle strobe; addr valid while high.
digit_sel  output  NUM_DIGITS  one-hot select of the digit being emitted; bit NUM_DIGITS-1 = most significant digit.
done  output  1  one-cycle pulse after the last digit is emitted.

Behaviour:
- Reset: synchronous on a rising clock edge with resetn=0. It is the only reset; clocking is single, on clock.
- Reset values: state=IDLE, busy=0, addr=4'hF, act_D=0, digit_sel=0, done=0, shift/BCD registers=0.
- Reset asserted in any state aborts the operation next edge. No partial digits or done follow.
- States: IDLE, CONVERT, EMIT, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge k latches bin_val and clears the BCD register.
  - Next state CONVERT; busy=1 from k+1.
  - start=0 keeps IDLE.
- CONVERT: exactly WIDTH cycles, with an iteration counter 0..WIDTH-1. Each cycle:
  - every BCD nibble >= 5 gets +3 (all nibbles in parallel);
  - then {bcd, bin} shifts left by 1.
  - After the final iteration the state goes to EMIT.
- EMIT: exactly NUM_DIGITS cycles, most significant digit first. Each cycle:
  - act_D=1;
  - addr = the corresponding nibble;
  - digit_sel one-hot for that digit.
  - Then the state goes to DONE.
- DONE: one cycle.
  - done=1, act_D=0, digit_sel=0, addr=4'hF.
  - Next state IDLE; busy falls with the IDLE entry.
- Latency: start sampled at edge k gives first act_D at cycle k+WIDTH+1, last act_D at k+WIDTH+NUM_DIGITS, and done at k+WIDTH+NUM_DIGITS+1. Default total is 12 cycles.
- start while busy (any non-IDLE state) is ignored, not queued. bin_val changes after the accept have no effect.
- start in the cycle after done (IDLE) is accepted normally, so back-to-back runs are allowed.
- Outside EMIT: act_D=0, digit_sel=0, addr=4'hF. 4'hF is a non-decimal code, so the decoder blanks.
- Arithmetic: the BCD register is 4*NUM_DIGITS bits. Add-3 is per nibble, without carry between nibbles. The elaboration check guarantees no overflow is possible.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: during EMIT, any zero digit more significant than the first non-zero digit is emitted as addr=4'hF, so it is blanked. The least significant digit is always emitted as a numeral, so 0 displays as a single '0'. act_D and digit_sel timing are unchanged.
- Undefined: all digits are emitted as numerals, including leading zeros.

Decomposition:
- Shared package:
  - state enum (IDLE, CONVERT, EMIT, DONE);
  - BLANK_CODE = 4'hF;
  - ADD3_THRESH = 4'd5;
  - BCD nibble typedef.
- One natural sub-module, bcd_add3_nibble: combinational "if >= 5 then +3" on one nibble, instantiated NUM_DIGITS times via generate.
- The FSM, counters and output registers stay in the top.

Test Plan:
- Reset, then start with bin_val=8'd173:
  - act_D high at cycles 9, 10, 11 after the start edge;
  - addr=1, 7, 3 with digit_sel=100, 010, 001;
  - done at cycle 12; busy low at cycle 13.
- bin_val=8'd255 → addr 2, 5, 5. bin_val=8'd9 → addr 0, 0, 9 (with LEAD_ZERO_BLANK_EN: F, F, 9).
- bin_val=0 → 0, 0, 0 (with LEAD_ZERO_BLANK_EN: F, F, 0). Also bin_val=8'd100 → 1, 0, 0 under both builds, checking that inner zeros are never blanked.
- Start 8'd42 at cycle 0, pulse start with 8'd99 at cycle 4 → the second start is ignored; output is 0, 4, 2 and there is exactly one done.
- resetn=0 at cycle 10 of a conversion → next edge:
  - all outputs return to reset values;
  - no further act_D or done;
  - a fresh start with 8'd7 then yields 0, 0, 7 normally.
- start held high continuously with bin_val=8'd1 → a new run every 13 cycles. Each run has exactly 3 act_D pulses and 1 done, with no act_D in the DONE or IDLE cycles.
